// File: rtl/pim_dma_pkg.sv
//==============================================================================
// Module   : pim_dma_pkg
// Purpose  : Shared types and constants for the PIM DMA controller.
//            Holds the controller state encoding, the address/length widths,
//            the per-word address stride and a word-alignment helper.
// Ports    : none (package)
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

package pim_dma_pkg;

  localparam int DMA_LEN_W  = 8;
  localparam int DMA_ADDR_W = 32;
  localparam int DMA_STRIDE = 4;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_REQ  = 3'd1,
    RD_WAIT = 3'd2,
    WR      = 3'd3,
    DONE    = 3'd4
  } dma_state_e;

  // Byte address -> 32-bit word address (low two bits cleared).
  function automatic logic [DMA_ADDR_W-1:0] word_align(input logic [DMA_ADDR_W-1:0] addr);
    return {addr[DMA_ADDR_W-1:2], 2'b00};
  endfunction

endpackage

`default_nettype wire

// File: rtl/pim_dma_ctrl.sv
//==============================================================================
// Module   : pim_dma_ctrl
// Purpose  : Single-channel word DMA that copies len words from DMEM to the
//            PIM array when the decoder issues a PIM opcode. Each word is one
//            DMEM read (req/gnt, then rvalid) followed by one PIM write
//            (valid/ready). The core pipeline is stalled for the whole
//            transfer, including the cycle in which the opcode is accepted.
// Ports    : clk_i, rst_ni          - clock, async active-low reset
//            dma_en_i               - issue strobe (ignored while busy)
//            src_addr_i, dst_addr_i - byte addresses, word-aligned on latch
//            len_i                  - word count, 0 = no transfer
//            stall_o, busy_o        - pipeline stall / transfer in progress
//            done_o                 - one-cycle completion pulse
//            dmem_req_o/addr_o/gnt_i/rvalid_i/rdata_i - DMEM read port
//            pim_valid_o/ready_i/addr_o/data_o        - PIM write port
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module pim_dma_ctrl
  import pim_dma_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  dma_en_i,
  input  logic [DMA_ADDR_W-1:0] src_addr_i,
  input  logic [DMA_ADDR_W-1:0] dst_addr_i,
  input  logic [DMA_LEN_W-1:0]  len_i,
  output logic                  stall_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  dmem_req_o,
  output logic [DMA_ADDR_W-1:0] dmem_addr_o,
  input  logic                  dmem_gnt_i,
  input  logic                  dmem_rvalid_i,
  input  logic [DMA_ADDR_W-1:0] dmem_rdata_i,
  output logic                  pim_valid_o,
  input  logic                  pim_ready_i,
  output logic [DMA_ADDR_W-1:0] pim_addr_o,
  output logic [DMA_ADDR_W-1:0] pim_data_o
);

  localparam logic [DMA_ADDR_W-1:0] STEP = DMA_ADDR_W'(DMA_STRIDE);
  localparam logic [DMA_LEN_W-1:0]  ONE  = DMA_LEN_W'(1);

  dma_state_e            state;
  dma_state_e            state_next;
  logic [DMA_ADDR_W-1:0] src_addr;
  logic [DMA_ADDR_W-1:0] dst_addr;
  logic [DMA_LEN_W-1:0]  count;
  logic [DMA_ADDR_W-1:0] data;

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and handshake outputs
  always_comb begin
    state_next  = state;
    dmem_req_o  = 1'b0;
    pim_valid_o = 1'b0;
    done_o      = 1'b0;
    busy_o      = 1'b1;
    case (state)
      IDLE: begin
        busy_o = 1'b0;
        if (dma_en_i) begin
          state_next = (len_i != '0) ? RD_REQ : DONE;
        end
      end
      RD_REQ: begin
        dmem_req_o = 1'b1;
        if (dmem_gnt_i) begin
          state_next = RD_WAIT;
        end
      end
      RD_WAIT: begin
        if (dmem_rvalid_i) begin
          state_next = WR;
        end
      end
      WR: begin
        pim_valid_o = 1'b1;
        if (pim_ready_i) begin
          state_next = (count == ONE) ? DONE : RD_REQ;
        end
      end
      DONE: begin
        done_o     = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // The accept cycle stalls combinationally from the strobe. Qualifying with
  // rst_ni keeps stall_o low while reset is held even if the decoder strobes.
  assign stall_o = busy_o | ((state == IDLE) & dma_en_i & rst_ni);

  // Address, count and data registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      src_addr <= '0;
      dst_addr <= '0;
      count    <= '0;
      data     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (dma_en_i) begin
            src_addr <= word_align(src_addr_i);
            dst_addr <= word_align(dst_addr_i);
            count    <= len_i;
          end
        end
        RD_WAIT: begin
          if (dmem_rvalid_i) begin
            data <= dmem_rdata_i;
          end
        end
        WR: begin
          if (pim_ready_i) begin
            // Natural 32-bit wrap past the top of the address space.
            src_addr <= src_addr + STEP;
            dst_addr <= dst_addr + STEP;
            count    <= count - ONE;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Address/data ports show the working registers directly; they only change
  // on a completed handshake, so they stay stable through any wait states.
  assign dmem_addr_o = src_addr;
  assign pim_addr_o  = dst_addr;
  assign pim_data_o  = data;

endmodule

`default_nettype wire

// File: tb/tb_pim_dma_ctrl.sv
//==============================================================================
// Module   : tb_pim_dma_ctrl
// Purpose  : Self-checking bench for pim_dma_ctrl. A reactive DMEM/PIM
//            responder inserts random (or fixed) wait states and logs every
//            completed read and write; each transfer is then compared with a
//            reference computed from src/dst/len and the chosen wait counts.
// Ports    : none
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_pim_dma_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        dma_en = 1'b0;
  logic [31:0] src_addr = '0;
  logic [31:0] dst_addr = '0;
  logic [7:0]  len = '0;
  logic        stall, busy, done;
  logic        dmem_req;
  logic [31:0] dmem_addr;
  logic        dmem_gnt = 1'b0;
  logic        dmem_rvalid = 1'b0;
  logic [31:0] dmem_rdata = '0;
  logic        pim_valid;
  logic        pim_ready = 1'b0;
  logic [31:0] pim_addr;
  logic [31:0] pim_data;

  always #5 clk = ~clk;

  pim_dma_ctrl dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .dma_en_i      (dma_en),
    .src_addr_i    (src_addr),
    .dst_addr_i    (dst_addr),
    .len_i         (len),
    .stall_o       (stall),
    .busy_o        (busy),
    .done_o        (done),
    .dmem_req_o    (dmem_req),
    .dmem_addr_o   (dmem_addr),
    .dmem_gnt_i    (dmem_gnt),
    .dmem_rvalid_i (dmem_rvalid),
    .dmem_rdata_i  (dmem_rdata),
    .pim_valid_o   (pim_valid),
    .pim_ready_i   (pim_ready),
    .pim_addr_o    (pim_addr),
    .pim_data_o    (pim_data)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // DMEM contents as seen by the bench: a fixed function of the word address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1234_5678;
  endfunction

  // Wait-state policy, written only by the stimulus process.
  int max_wait = 0;
  bit use_fixed = 1'b0;
  int fix_gw = 0, fix_rw = 0, fix_yw = 0;

  function automatic int pick(input int fixed);
    if (use_fixed) return fixed;
    return int'($urandom_range(max_wait, 0));
  endfunction

  // Responder / monitor state, written only by the responder process.
  int          stall_cnt = 0, done_cnt = 0, wait_sum = 0;
  int          stab_viol = 0, excl_viol = 0;
  int          gw_left = 0, rw_left = 0, yw_left = 0;
  bit          dmem_active = 1'b0, rv_armed = 1'b0, wr_active = 1'b0;
  logic [31:0] held_addr = '0, held_waddr = '0, held_wdata = '0, pend_data = '0;
  logic [31:0] rd_log[$];
  logic [31:0] wa_log[$];
  logic [31:0] wd_log[$];

  always @(negedge clk) begin
    if (!rst_n) begin
      dmem_active = 1'b0;
      rv_armed    = 1'b0;
      wr_active   = 1'b0;
      dmem_gnt    = 1'b0;
      dmem_rvalid = 1'b0;
      pim_ready   = 1'b0;
    end else begin
      if (stall) stall_cnt++;
      if (done)  done_cnt++;
      if (dmem_req && pim_valid) excl_viol++;
      if (!busy && (dmem_req || pim_valid || done)) excl_viol++;

      // Read data return; stray rvalid/rdata when no read is outstanding.
      if (rv_armed) begin
        if (rw_left == 0) begin
          dmem_rvalid = 1'b1;
          dmem_rdata  = pend_data;
          rv_armed    = 1'b0;
        end else begin
          dmem_rvalid = 1'b0;
          dmem_rdata  = $urandom;
          rw_left--;
        end
      end else begin
        dmem_rvalid = 1'($urandom_range(1, 0));
        dmem_rdata  = $urandom;
      end

      // Read request / grant.
      if (dmem_req) begin
        if (!dmem_active) begin
          dmem_active = 1'b1;
          held_addr   = dmem_addr;
          gw_left     = pick(fix_gw);
          wait_sum   += gw_left;
        end else if (dmem_addr !== held_addr) begin
          stab_viol++;
        end
        if (gw_left == 0) begin
          dmem_gnt    = 1'b1;
          rd_log.push_back(dmem_addr);
          pend_data   = mem_word(dmem_addr);
          rv_armed    = 1'b1;
          rw_left     = pick(fix_rw);
          wait_sum   += rw_left;
          dmem_active = 1'b0;
        end else begin
          dmem_gnt = 1'b0;
          gw_left--;
        end
      end else begin
        dmem_gnt = 1'($urandom_range(1, 0));
      end

      // PIM write acceptance; stray ready when no write is offered.
      if (pim_valid) begin
        if (!wr_active) begin
          wr_active  = 1'b1;
          held_waddr = pim_addr;
          held_wdata = pim_data;
          yw_left    = pick(fix_yw);
          wait_sum  += yw_left;
        end else if (pim_addr !== held_waddr || pim_data !== held_wdata) begin
          stab_viol++;
        end
        if (yw_left == 0) begin
          pim_ready = 1'b1;
          wa_log.push_back(pim_addr);
          wd_log.push_back(pim_data);
          wr_active = 1'b0;
        end else begin
          pim_ready = 1'b0;
          yw_left--;
        end
      end else begin
        pim_ready = 1'($urandom_range(1, 0));
      end
    end
  end

  // One complete transfer plus all its checks against the reference.
  task automatic run_xfer(input logic [31:0] s, input logic [31:0] d,
                          input logic [7:0] n, input bit poke);
    int rb, wb, sb, db, ws0, sv0, ev0, cyc, exp_stall;
    bit seen;
    logic [31:0] ra, wa;
    rb  = rd_log.size();
    wb  = wa_log.size();
    sb  = stall_cnt;
    db  = done_cnt;
    ws0 = wait_sum;
    sv0 = stab_viol;
    ev0 = excl_viol;
    @(posedge clk); #1;
    src_addr = s; dst_addr = d; len = n; dma_en = 1'b1;
    @(posedge clk); #1;
    dma_en = 1'b0; src_addr = $urandom; dst_addr = $urandom; len = 8'($urandom);
    seen = done;
    cyc  = 0;
    while (!seen && cyc < 4000) begin
      if (poke && busy && !done) dma_en = 1'($urandom_range(1, 0));
      @(posedge clk); #1;
      dma_en = 1'b0;
      cyc++;
      seen = done;
    end
    check("done_seen", 32'(seen), 32'd1);
    @(posedge clk); #1;
    check("idle_after", {29'd0, busy, stall, done}, 32'd0);
    @(posedge clk); #1;
    // Each word costs RD_REQ+RD_WAIT+WR plus its waits; +1 accept, +1 DONE.
    exp_stall = 2 + 3 * int'(n) + (wait_sum - ws0);
    check("stall_cycles", 32'(stall_cnt - sb), 32'(exp_stall));
    check("done_pulses", 32'(done_cnt - db), 32'd1);
    check("read_count", 32'(rd_log.size() - rb), 32'(n));
    check("write_count", 32'(wa_log.size() - wb), 32'(n));
    check("held_stable", 32'(stab_viol - sv0), 32'd0);
    check("port_exclusive", 32'(excl_viol - ev0), 32'd0);
    ra = {s[31:2], 2'b00};
    wa = {d[31:2], 2'b00};
    for (int i = 0; i < int'(n); i++) begin
      if (rb + i < rd_log.size()) check("rd_addr", rd_log[rb + i], ra);
      if (wb + i < wa_log.size()) begin
        check("wr_addr", wa_log[wb + i], wa);
        check("wr_data", wd_log[wb + i], mem_word(ra));
      end
      ra = ra + 32'd4;
      wa = wa + 32'd4;
    end
  endtask

  initial begin
    int db, cyc;
    // Reset state, with the issue strobe high to show it is masked.
    dma_en = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_ctrl", {27'd0, stall, busy, done, dmem_req, pim_valid}, 32'd0);
    check("reset_dmem_addr", dmem_addr, 32'd0);
    check("reset_pim_addr", pim_addr, 32'd0);
    check("reset_pim_data", pim_data, 32'd0);
    dma_en = 1'b0;
    rst_n  = 1'b1;
    repeat (2) @(posedge clk);

    // Zero-wait transfers: basic, empty, wrap-around.
    max_wait = 0;
    run_xfer(32'h0000_0100, 32'h8000_0000, 8'd3, 1'b0);
    run_xfer(32'h0000_0200, 32'h0000_1000, 8'd0, 1'b0);
    run_xfer(32'hFFFF_FFFE, 32'h4000_0003, 8'd2, 1'b0);

    // Backpressure on one word: gnt two cycles after req rises, rvalid three
    // cycles after the grant, ready low for four cycles from the rvalid cycle.
    use_fixed = 1'b1; fix_gw = 2; fix_rw = 2; fix_yw = 3;
    run_xfer(32'h0000_0400, 32'h0000_2000, 8'd1, 1'b0);
    use_fixed = 1'b0;

    // Issue strobes while busy must be ignored.
    max_wait = 2;
    run_xfer(32'h0000_3000, 32'h9000_0010, 8'd5, 1'b1);

    // Reset during a write of a 4-word transfer.
    max_wait = 0;
    db = done_cnt;
    @(posedge clk); #1;
    src_addr = 32'h0000_0800; dst_addr = 32'h0000_5000; len = 8'd4; dma_en = 1'b1;
    @(posedge clk); #1;
    dma_en = 1'b0;
    cyc = 0;
    while (!(pim_valid && wa_log.size() > 0 && cyc > 4) && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("reached_wr", 32'(pim_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_mid_ctrl", {27'd0, stall, busy, done, dmem_req, pim_valid}, 32'd0);
    check("rst_mid_regs", dmem_addr | pim_addr | pim_data, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_no_done", 32'(done_cnt - db), 32'd0);
    run_xfer(32'h0000_0C00, 32'h0000_6000, 8'd1, 1'b0);

    // Randomized transfers with random wait states and busy-time strobes.
    max_wait = 3;
    for (int t = 0; t < 10; t++) begin
      run_xfer($urandom, $urandom, 8'($urandom_range(6, 0)), 1'($urandom_range(1, 0)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/pim_dma_ctrl.md
PIM_DMA_CTRL -- requirements
Module: pim_dma_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset: clk_i and rst_ni.
REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk_i  in  1  clock
- rst_ni  in  1  async active-low reset
- dma_en_i  in  1  PIM-opcode issue strobe from decoder
- src_addr_i  in  32  DMEM source byte address (rs1 value)
- dst_addr_i  in  32  PIM destination byte address (rs2 value)
- len_i  in  8  word count; 0 means no transfer
- stall_o  out  1  core pipeline stall
- busy_o  out  1  transfer in progress
- done_o  out  1  one-cycle completion pulse
- dmem_req_o  out  1  DMEM read request
- dmem_addr_o  out  32  DMEM word address
- dmem_gnt_i  in  1  DMEM grant
- dmem_rvalid_i  in  1  DMEM read data valid
- dmem_rdata_i  in  32  DMEM read data
- pim_valid_o  out  1  PIM write valid
- pim_ready_i  in  1  PIM write ready
- pim_addr_o  out  32  PIM word address
- pim_data_o  out  32  PIM write data

Function
REQ-003 The FSM SHALL have these states: IDLE, RD_REQ, RD_WAIT, WR and DONE.
REQ-004 In IDLE, dma_en_i=1 SHALL latch src, dst (bits [1:0] forced to 0) and len, then go to RD_REQ if len!=0, otherwise to DONE.
REQ-005 RD_REQ SHALL hold dmem_req_o=1 with dmem_addr_o equal to the current src address; dmem_gnt_i=1 SHALL move the FSM to RD_WAIT.
REQ-006 RD_WAIT SHALL wait for dmem_rvalid_i=1, capture dmem_rdata_i into the data register, and move to WR.
REQ-007 WR SHALL hold pim_valid_o=1 with pim_addr_o/pim_data_o stable until pim_valid_o&&pim_ready_i.
REQ-008 On each WR handshake: src+=4 and dst+=4 (mod 2^32 wrap), count-=1; the FSM SHALL go to DONE if count was 1, otherwise to RD_REQ.
REQ-009 DONE SHALL last exactly one cycle with done_o=1 and SHALL then return to IDLE.
REQ-010 Signal definitions:
- busy_o=(state!=IDLE)
- stall_o=busy_o | (state==IDLE & dma_en_i), combinational
REQ-011 With zero wait states (gnt, rvalid and ready all 1), an N-word transfer SHALL keep stall_o high for 3N+2 cycles, including the accept cycle; for len=0 this is 2 cycles.
REQ-012 dma_en_i SHALL be ignored while busy_o=1; no queuing is performed.
REQ-013 dmem_rvalid_i outside RD_WAIT and pim_ready_i outside WR SHALL be ignored.
REQ-014 dmem_req_o SHALL NOT be asserted outside RD_REQ, and pim_valid_o SHALL NOT be asserted outside WR.
REQ-015 Wait states on gnt, rvalid or ready SHALL stretch their state indefinitely, with outputs held stable.

Reset
REQ-016 On rst_ni=0 the FSM SHALL enter IDLE immediately and all outputs SHALL be 0; address, count and data registers SHALL clear to 0.
REQ-017 A reset mid-transfer SHALL abandon the transfer with no done_o pulse; a later dma_en_i SHALL start cleanly.

Structure
REQ-018 Package pim_dma_pkg SHALL hold:
- state enum dma_state_e
- DMA_LEN_W=8
- DMA_ADDR_W=32
- DMA_STRIDE=4
REQ-019 The block SHALL be a single module with no sub-modules.

Verification
REQ-020 Basic transfer: src=0x100, dst=0x8000_0000, len=3, zero waits -> DMEM reads at 0x100/0x104/0x108, PIM writes at 0x8000_0000/4/8 with matching data, done_o 1 cycle, stall_o high 11 cycles.
REQ-021 len=0 -> no dmem_req_o or pim_valid_o, done_o on the 2nd cycle, stall_o high 2 cycles.
REQ-022 Backpressure: gnt delayed 2 cycles, rvalid delayed 3, ready low 4 cycles, len=1 -> outputs stable while waiting, a single write of the correct data, stall 12 cycles.
REQ-023 Wrap and alignment: src=0xFFFF_FFFE, len=2 -> read addresses 0xFFFF_FFFC then 0x0000_0000.
REQ-024 Reset mid-transfer during WR with len=4 -> all outputs 0 immediately, no done_o pulse; a new dma_en_i with len=1 then completes normally.
REQ-025 dma_en_i pulsed while busy -> ignored; exactly len writes occur and a single done_o pulse.
